// File: rtl/encrypter_seq_ctrl_if.sv
// Requester handshakes plus the byte-wide encrypter register bus driven by encrypter_seq_ctrl.
interface encrypter_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;

  modport master (
    input  in_valid, in_data, in_key, out_ready, reg_rdata,
    output in_ready, out_valid, out_data, busy, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output in_valid, in_data, in_key, out_ready, reg_rdata,
    input  in_ready, out_valid, out_data, busy, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/encrypter_seq_ctrl.sv
// Runs the cmd/data/key/clear/wait/read protocol on the encrypter register bus for one
// 64-bit request at a time and hands the 64-bit result back over a valid/ready handshake.
module encrypter_seq_ctrl #(
  parameter logic [7:0]  START_CMD = 8'h80,
  parameter int unsigned CORE_LAT  = 10,
  parameter int unsigned READ_LAT  = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  encrypter_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, WR_KEY, WR_CLR, WAIT, RD, DONE} state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(CORE_LAT - 1);
  localparam logic [1:0] SLOT_LAST = 2'(READ_LAT);

  state_t      state, state_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  wait_cnt, wait_cnt_d;
  logic [1:0]  slot_cnt, slot_cnt_d;
  logic [63:0] data_q, key_q, out_data_q;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d, re_q, re_d, out_valid_q;
  logic        accept, slot_end;

  assign accept   = bus.in_valid && (state == IDLE);
  assign slot_end = (slot_cnt == SLOT_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state;
    idx_d      = idx;
    wait_cnt_d = wait_cnt;
    slot_cnt_d = slot_cnt;
    case (state)
      IDLE:    if (bus.in_valid) state_d = WR_CMD;
      WR_CMD:  begin state_d = WR_DATA; idx_d = '0; end
      WR_DATA: begin idx_d = idx + 3'd1; if (idx == 3'd7) state_d = WR_KEY; end
      WR_KEY:  begin idx_d = idx + 3'd1; if (idx == 3'd7) state_d = WR_CLR; end
      WR_CLR: begin
        idx_d      = '0;
        slot_cnt_d = '0;
        if (CORE_LAT == 0) begin
          state_d = RD;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      WAIT: if (wait_cnt == 8'd0) state_d = RD; else wait_cnt_d = wait_cnt - 8'd1;
      RD: begin
        if (slot_end) begin
          slot_cnt_d = '0;
          idx_d      = idx + 3'd1;
          if (idx == 3'd7) state_d = DONE;
        end else begin
          slot_cnt_d = slot_cnt + 2'd1;
        end
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus values are decoded from the next state so the registered outputs line up with it.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    case (state_d)
      WR_CMD:  begin we_d = 1'b1; wdata_d = START_CMD; end
      WR_DATA: begin
        we_d    = 1'b1;
        addr_d  = 6'd1 + {3'b000, idx_d};
        wdata_d = data_q[{~idx_d, 3'b000} +: 8];
      end
      WR_KEY: begin
        we_d    = 1'b1;
        addr_d  = 6'd17 + {3'b000, idx_d};
        wdata_d = key_q[{~idx_d, 3'b000} +: 8];
      end
      WR_CLR:  we_d = 1'b1;
      RD:      begin re_d = 1'b1; addr_d = 6'd9 + {3'b000, idx_d}; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      slot_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      wait_cnt    <= wait_cnt_d;
      slot_cnt    <= slot_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      key_q      <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) begin
        data_q <= bus.in_data;
        key_q  <= bus.in_key;
      end
      if (state == RD && slot_end) out_data_q[{~idx, 3'b000} +: 8] <= bus.reg_rdata;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
endmodule

// File: doc/encrypter_seq_ctrl.md
Name: encrypter_seq_ctrl

Overview:
Sequencer that drives the byte-wide register port of the encrypter register block on behalf of one requester. It accepts a 64-bit data block and a 64-bit round key over a valid/ready handshake. It then runs the write/start/wait/read protocol on the register bus (cmd, data bytes, key bytes, cmd clear, wait, result bytes) and returns the 64-bit result over a second valid/ready handshake. It sits between the system-side requester and the encrypter register interface.

Parameters:
START_CMD, 8'h80, byte written to cmd register (addr 0) to start a load.
CORE_LAT, 10, idle cycles between the cmd-clear write and the first result read (range 0..255).
READ_LAT, 0, cycles from reg_addr/reg_re valid to reg_rdata valid (range 0..3).

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request present.
in_ready  out  1  controller can accept a request.
in_data  in  64  data block; byte k = in_data[63-8k -: 8].
in_key  in  64  round key; same byte order.
out_valid  out  1  result available.
out_ready  in  1  requester takes the result.
out_data  out  64  result; byte k from read address 9+k placed at [63-8k -: 8].
busy  out  1  high in every state except IDLE.
reg_addr  out  6  register address to encrypter register block.
reg_wdata  out  8  write byte, MSB-first.
reg_we  out  1  write enable.
reg_re  out  1  read enable.
reg_rdata  in  8  read byte from encrypter register block.

Behaviour:
- Reset (rst_n low, any state): state=IDLE; reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, out_valid=0, out_data=0, busy=0; byte and wait counters cleared. Takes effect mid-operation with no completion and no partial output.
- Bus outputs (reg_*) are registered. in_ready = (state==IDLE) and is 1 from the first cycle after reset release.
- Accept: in_valid && in_ready at an edge latches in_data/in_key into internal registers. Later input changes are ignored. in_valid while not IDLE is ignored (no queueing).
- Cycle numbering below counts cycles after the accept edge.
- States and register-bus activity:
  - WR_CMD (cycle 1): we=1, addr=0, wdata=START_CMD.
  - WR_DATA (cycles 2..9): we=1, addr=1..8, wdata=data byte 0..7.
  - WR_KEY (cycles 10..17): we=1, addr=17..24, wdata=key byte 0..7.
  - WR_CLR (cycle 18): we=1, addr=0, wdata=0.
  - WAIT (CORE_LAT cycles): we=0, re=0, addr=0. With CORE_LAT=0 this state is skipped and WR_CLR goes directly to RD.
  - RD: 8 slots of READ_LAT+1 cycles each. In slot k, re=1 and addr=9+k for the whole slot. reg_rdata is sampled into out_data byte k at the last edge of the slot.
  - DONE: re=0, we=0, addr=0; out_valid=1; out_data stable.
- out_valid first high at cycle 18+CORE_LAT+8*(READ_LAT+1)+1. Defaults give cycle 37.
- DONE -> IDLE on out_valid && out_ready; out_valid drops next cycle. out_ready held low means DONE is held indefinitely and no new request is accepted. out_ready high on the first DONE cycle gives a 1-cycle out_valid pulse.
- A new accept is possible no earlier than the cycle after the DONE exit (no overlap between requests).
- reg_we and reg_re are never high in the same cycle. Neither is high in IDLE, WAIT or DONE.
- Counters: 3-bit byte index wraps 7->0 only on a state change. The wait counter is 8 bits wide, loaded with CORE_LAT-1 and counts down to 0.

Test Plan:
- Basic vector: bench model of the register block returns data XOR key. Stimulus: in_data=64'h0123456789abcdef, in_key=64'h0102030405060708, defaults. Required: out_data=64'h002146638cadcae7, out_valid high at cycle 37, and the write trace is exactly addr 0(80),1..8(01,23,45,67,89,ab,cd,ef),17..24(01..08),0(00).
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out_valid and out_data stable throughout; in_ready=0; a second in_valid during this time is not accepted. After out_ready=1 for one edge, the controller is back in IDLE with in_ready=1.
- Busy drop: assert in_valid with new data at cycle 5 of a running request. Required: ignored. The register-bus trace still carries the first request's bytes.
- Reset mid-op: pull rst_n low during WR_KEY (cycle 12). Required: all outputs 0 asynchronously, with out_valid never asserted. After release, a fresh request completes correctly in 37 cycles.
- Parameter corners: CORE_LAT=0, READ_LAT=2 with a model that adds a 2-cycle read delay. Required: RD immediately follows WR_CLR, each read address held 3 cycles, out_valid at cycle 43, and the same XOR result.
- Back-to-back: two requests with out_ready tied 1. Required: the second is accepted the cycle after the first out_valid pulse, and both results are correct.
